// File: rtl/axi_burst_splitter_pkg.sv
// Shared types and constants for the AXI burst splitter.
package axi_burst_splitter_pkg;

   localparam int ID_WIDTH   = 4;
   localparam int USER_WIDTH = 1;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // B channel at the default widths, MSB to LSB: id, resp, user.
   typedef struct packed {
      logic [ID_WIDTH-1:0]   id;
      logic [1:0]            resp;
      logic [USER_WIDTH-1:0] user;
   } b_chan_t;

   typedef enum logic {
      OBUF_EMPTY = 1'b0,
      OBUF_FULL  = 1'b1
   } obuf_state_e;

   // Worst error wins: a last-beat SLVERR/DECERR is kept as is, an earlier
   // error on the burst turns an OKAY/EXOKAY last beat into SLVERR.
   function automatic logic [1:0] merge_resp(input logic [1:0] resp,
                                             input logic       err);
      if (resp[1])
         return resp;
      else if (err)
         return RESP_SLVERR;
      else
         return resp;
   endfunction

endpackage

// File: rtl/axi_burst_splitter_b_obuf.sv
// One-entry output register for merged B responses. A load may land in
// the same cycle the held entry drains, so full throughput needs no bubble.
module axi_burst_splitter_b_obuf
   import axi_burst_splitter_pkg::*;
#(
   parameter int Width = 7
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [Width-1:0] data_i,
   input  logic             ready_i,
   output logic             valid_o,
   output logic [Width-1:0] data_o,
   output logic             full_o,
   output logic             ready_for_load_o
);

   obuf_state_e      state, state_next;
   logic [Width-1:0] data;

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i)
         state <= OBUF_EMPTY;
      else
         state <= state_next;
   end

   // Next state: load wins over drain, drain alone empties the entry.
   always_comb begin
      state_next = state;
      case (state)
         OBUF_EMPTY: if (load_i) state_next = OBUF_FULL;
         OBUF_FULL: begin
            if (load_i)       state_next = OBUF_FULL;
            else if (ready_i) state_next = OBUF_EMPTY;
         end
         default: state_next = OBUF_EMPTY;
      endcase
   end

   // Payload only changes on load, which keeps it stable while stalled.
   always_ff @(posedge clk_i) begin
      if (rst_i)
         data <= '0;
      else if (load_i)
         data <= data_i;
   end

   assign full_o           = (state == OBUF_FULL);
   assign valid_o          = full_o;
   assign data_o           = data;
   assign ready_for_load_o = !full_o || ready_i;

endmodule

// File: rtl/axi_burst_splitter_b_chan.sv
// Merges the per-sub-transaction B responses back into one B per original
// burst. Non-last beats only update the shared counter; the last beat of a
// burst carries the merged response into the output register.
module axi_burst_splitter_b_chan
   import axi_burst_splitter_pkg::*;
#(
   parameter int IdWidth   = 4,
   parameter int UserWidth = 1,
   parameter int BW        = IdWidth + 2 + UserWidth
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [BW-1:0]      b_i,
   input  logic               b_valid_i,
   output logic               b_ready_o,
   output logic [BW-1:0]      b_o,
   output logic               b_valid_o,
   input  logic               b_ready_i,
   output logic [IdWidth-1:0] cnt_id_o,
   input  logic [7:0]         cnt_len_i,
   input  logic               cnt_err_i,
   output logic               cnt_set_err_o,
   output logic               cnt_dec_o,
   output logic               cnt_req_o,
   input  logic               cnt_gnt_i
);

   typedef struct packed {
      logic [IdWidth-1:0]   id;
      logic [1:0]           resp;
      logic [UserWidth-1:0] user;
   } b_t;

   b_t   beat;
   b_t   merged;
   logic is_last;
   logic ready_for_load;
   logic full;
   logic handshake;
   logic load;

   assign beat      = b_t'(b_i);
   assign cnt_req_o = b_valid_i;
   assign cnt_id_o  = beat.id;
   assign is_last   = (cnt_len_i == 8'd0);

   // Acceptance: non-last beats always pass when granted; the last beat
   // needs room in the output register (possibly freed this same cycle).
   always_comb begin
      b_ready_o = 1'b0;
      if (cnt_gnt_i)
         b_ready_o = is_last ? ready_for_load : 1'b1;
   end

   // Counter side effects only on an actual handshake.
   always_comb begin
      handshake     = b_valid_i && b_ready_o && cnt_gnt_i;
      load          = handshake && is_last;
      cnt_dec_o     = handshake;
      cnt_set_err_o = handshake && !is_last && beat.resp[1];
   end

   // Merged response for the last beat, folding in the sticky error.
   always_comb begin
      merged      = beat;
      merged.resp = merge_resp(beat.resp, cnt_err_i);
   end

   axi_burst_splitter_b_obuf #(
      .Width(BW)
   ) u_obuf (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .load_i           (load),
      .data_i           (merged),
      .ready_i          (b_ready_i),
      .valid_o          (b_valid_o),
      .data_o           (b_o),
      .full_o           (full),
      .ready_for_load_o (ready_for_load)
   );

   // The register occupancy is fully reflected by ready_for_load; kept
   // for debug visibility.
   logic unused;
   assign unused = full;

endmodule

// File: tb/tb_axi_burst_splitter_b_chan.sv
// Bench for the B-channel merger: counter model, randomized beats, scoreboard.
module tb_axi_burst_splitter_b_chan;

   logic       clk = 1'b0;
   logic       rst_i;
   logic [6:0] b_i;
   logic       b_valid_i;
   logic       b_ready_o;
   logic [6:0] b_o;
   logic       b_valid_o;
   logic       b_ready_i;
   logic [3:0] cnt_id_o;
   logic [7:0] cnt_len_i;
   logic       cnt_err_i;
   logic       cnt_set_err_o;
   logic       cnt_dec_o;
   logic       cnt_req_o;
   logic       cnt_gnt_i;

   always #5 clk = ~clk;

   axi_burst_splitter_b_chan #(.IdWidth(4), .UserWidth(1)) dut (
      .clk_i(clk), .rst_i(rst_i), .b_i(b_i), .b_valid_i(b_valid_i),
      .b_ready_o(b_ready_o), .b_o(b_o), .b_valid_o(b_valid_o),
      .b_ready_i(b_ready_i), .cnt_id_o(cnt_id_o), .cnt_len_i(cnt_len_i),
      .cnt_err_i(cnt_err_i), .cnt_set_err_o(cnt_set_err_o),
      .cnt_dec_o(cnt_dec_o), .cnt_req_o(cnt_req_o), .cnt_gnt_i(cnt_gnt_i)
   );

   // Counter emulation (what the shared counter block would hold).
   logic [7:0] cnt_rem [16];
   logic       cnt_err [16];
   assign cnt_len_i = cnt_rem[cnt_id_o];
   assign cnt_err_i = cnt_err[cnt_id_o];

   // Burst-level reference state.
   int         act_rem [16];
   bit         exp_err [16];
   logic [6:0] exp_q[$];

   int checks = 0, passed = 0;
   int accepted = 0, dec_seen = 0;
   bit force_mode = 1'b1;
   int stall = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
   endtask

   // Upstream ready / counter grant drivers.
   initial begin
      b_ready_i = 1'b1;
      cnt_gnt_i = 1'b1;
      forever begin
         @(posedge clk); #2;
         if (force_mode) begin
            cnt_gnt_i = 1'b1;
            if (stall > 0) begin b_ready_i = 1'b0; stall--; end
            else b_ready_i = 1'b1;
         end else begin
            cnt_gnt_i = ($urandom_range(0, 4) != 0);
            b_ready_i = ($urandom_range(0, 3) != 0);
         end
      end
   end

   // Present one beat until accepted; check the per-cycle handshake rules.
   task automatic send(input logic [3:0] id, input logic [1:0] resp, input logic user,
                       input bit last, output int cyc);
      bit hs = 1'b0;
      bit se = 1'b0;
      cyc = 0;
      b_i = {id, resp, user};
      b_valid_i = 1'b1;
      while (!hs && cyc < 200) begin
         @(negedge clk);
         chk("cnt_req", cnt_req_o, 1);
         chk("cnt_id", cnt_id_o, id);
         if (!cnt_gnt_i) chk("nogrant_ready", b_ready_o, 0);
         else if (!last || b_ready_i || !b_valid_o) chk("ready_open", b_ready_o, 1);
         else chk("last_stall", b_ready_o, 0);
         hs = cnt_gnt_i && b_ready_o;
         chk("cnt_dec", cnt_dec_o, hs);
         chk("cnt_set_err", cnt_set_err_o, hs && !last && resp[1]);
         se = hs && cnt_set_err_o;
         @(posedge clk); #1;
         cyc++;
      end
      b_valid_i = 1'b0;
      if (!hs) chk("beat_timeout", 0, 1);
      else begin
         accepted++;
         if (last) begin
            cnt_err[id] = 1'b0;
            chk("latency", b_valid_o, 1);
         end else begin
            cnt_rem[id] = cnt_rem[id] - 8'd1;
            if (se) cnt_err[id] = 1'b1;
         end
      end
   endtask

   task automatic start_burst(input logic [3:0] id, input int len);
      act_rem[id] = len;
      exp_err[id] = 1'b0;
      cnt_rem[id] = 8'(len - 1);
      cnt_err[id] = 1'b0;
   endtask

   // Issue the next beat of a burst; the last one predicts the merged B.
   task automatic beat(input logic [3:0] id, input logic [1:0] resp, input logic user,
                       output int cyc);
      bit last = (act_rem[id] == 1);
      logic [1:0] r;
      if (!last) exp_err[id] = exp_err[id] | resp[1];
      else begin
         r = resp[1] ? resp : (exp_err[id] ? 2'b10 : resp);
         exp_q.push_back({id, r, user});
      end
      act_rem[id] = act_rem[id] - 1;
      send(id, resp, user, last, cyc);
   endtask

   // Monitor: scoreboard pops, stability while stalled, decrement tally.
   initial begin
      bit prev_stall = 1'b0;
      logic [6:0] held = '0;
      logic [6:0] e;
      forever begin
         @(negedge clk);
         if (rst_i) prev_stall = 1'b0;
         else begin
            if (cnt_dec_o) dec_seen++;
            if (prev_stall) begin
               chk("hold_valid", b_valid_o, 1);
               chk("hold_data", b_o, held);
            end
            if (b_valid_o && b_ready_i) begin
               if (exp_q.size() == 0) chk("unexpected_b", 1, 0);
               else begin
                  e = exp_q.pop_front();
                  chk("b_out", b_o, e);
               end
            end
            prev_stall = b_valid_o && !b_ready_i;
            held = b_o;
         end
      end
   end

   initial begin
      int cyc;
      int w;
      logic [3:0] id;
      logic [1:0] rs;
      int r;
      for (int i = 0; i < 16; i++) begin
         cnt_rem[i] = 8'd0; cnt_err[i] = 1'b0; act_rem[i] = 0; exp_err[i] = 1'b0;
      end
      rst_i = 1'b1; b_valid_i = 1'b0; b_i = '0;
      repeat (3) @(posedge clk);
      #1 rst_i = 1'b0;
      chk("reset_valid", b_valid_o, 0);
      chk("reset_data", b_o, 0);

      // Single-beat burst.
      start_burst(4'd3, 1); beat(4'd3, 2'b00, 1'b0, cyc);
      // Error merge over a 4-beat burst.
      start_burst(4'd1, 4);
      beat(4'd1, 2'b00, 1'b0, cyc); beat(4'd1, 2'b10, 1'b0, cyc);
      beat(4'd1, 2'b00, 1'b0, cyc); beat(4'd1, 2'b00, 1'b1, cyc);
      // Worst error wins.
      start_burst(4'd4, 2);
      beat(4'd4, 2'b10, 1'b0, cyc); beat(4'd4, 2'b11, 1'b0, cyc);
      repeat (2) @(posedge clk); #1;

      // Back-pressure: non-last absorb while stalled, last waits, then
      // drain and refill in one cycle.
      stall = 6;
      start_burst(4'd7, 1); beat(4'd7, 2'b01, 1'b1, cyc);
      start_burst(4'd2, 3);
      beat(4'd2, 2'b00, 1'b0, cyc); chk("nonlast_absorb0", cyc, 1);
      beat(4'd2, 2'b10, 1'b0, cyc); chk("nonlast_absorb1", cyc, 1);
      beat(4'd2, 2'b00, 1'b1, cyc); chk("drain_refill", cyc, 4);

      // Back-to-back singles.
      for (int i = 0; i < 4; i++) begin
         start_burst(4'(i), 1);
         beat(4'(i), 2'b00, 1'(i), cyc);
         chk("b2b_accept", cyc, 1);
      end
      repeat (3) @(posedge clk); #1;

      // Reset while FULL.
      stall = 100;
      start_burst(4'd5, 1); beat(4'd5, 2'b00, 1'b1, cyc);
      rst_i = 1'b1;
      @(posedge clk); #1;
      rst_i = 1'b0;
      stall = 0;
      chk("rst_mid_valid", b_valid_o, 0);
      chk("rst_mid_data", b_o, 0);
      exp_q.delete();
      start_burst(4'd6, 1); beat(4'd6, 2'b10, 1'b0, cyc);
      repeat (2) @(posedge clk); #1;

      // Randomized interleaved bursts.
      force_mode = 1'b0;
      for (int n = 0; n < 300; n++) begin
         id = 4'($urandom_range(0, 15));
         if (act_rem[id] == 0) start_burst(id, $urandom_range(1, 6));
         r = $urandom_range(0, 9);
         rs = (r == 0) ? 2'b10 : (r == 1) ? 2'b11 : (r == 2) ? 2'b01 : 2'b00;
         beat(id, rs, 1'($urandom_range(0, 1)), cyc);
         if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      end

      force_mode = 1'b1;
      stall = 0;
      w = 0;
      while (exp_q.size() != 0 && w < 50) begin @(posedge clk); #1; w++; end
      repeat (2) @(posedge clk); #1;
      chk("drain_empty", exp_q.size(), 0);
      chk("dec_count", dec_seen, accepted);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/axi_burst_splitter_b_chan.md
# axi_burst_splitter_b_chan

Response-side counterpart of the burst splitter's address-channel path. It receives the single-beat write responses (B) that downstream returns for each split sub-transaction and merges them back into one B response per original burst. Per-ID beat counts and error flags come from the shared `axi_burst_splitter_counters` instance through its `cnt_*` port. The block sits between the downstream B channel and the upstream slave port.

## Interface
- `IdWidth`, 4, AXI ID width; also the counter lookup ID width.
- `UserWidth`, 1, B user width.
- B channel packing, MSB→LSB: `{id[IdWidth], resp[2], user[UserWidth]}`; `BW = IdWidth+2+UserWidth`.

Ports:
- `clk_i`  in  1  single clock; all logic on rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `b_i`  in  BW  downstream single-beat response.
- `b_valid_i`  in  1  downstream valid.
- `b_ready_o`  out  1  downstream ready.
- `b_o`  out  BW  merged upstream response.
- `b_valid_o`  out  1  upstream valid.
- `b_ready_i`  in  1  upstream ready.
- `cnt_id_o`  out  IdWidth  counter lookup ID (= `b_i.id`).
- `cnt_len_i`  in  8  remaining beats minus one for `cnt_id_o`.
- `cnt_err_i`  in  1  sticky error flag for `cnt_id_o`.
- `cnt_set_err_o`  out  1  set the sticky error for `cnt_id_o`.
- `cnt_dec_o`  out  1  decrement the counter for `cnt_id_o`.
- `cnt_req_o`  out  1  counter port request.
- `cnt_gnt_i`  in  1  counter port grant, same cycle, combinational.

## Operation
- Output register states: EMPTY and FULL.
- **Lookup**
  - `cnt_req_o = b_valid_i`.
  - `cnt_id_o = b_i.id` at all times.
  - `cnt_len_i` and `cnt_err_i` are valid in the cycle `cnt_gnt_i` is high.
- **Beat classification** (while `b_valid_i & cnt_gnt_i`): a beat is last when `cnt_len_i == 0`.
- **Non-last beat**
  - `b_ready_o = 1` regardless of output register state; non-last beats are never blocked by upstream back-pressure.
  - On acceptance: `cnt_dec_o = 1`.
  - On acceptance, `cnt_set_err_o = b_i.resp[1]`, i.e. SLVERR or DECERR.
  - Nothing is emitted upstream.
- **Last beat**
  - `b_ready_o = 1` iff the output register is EMPTY, or FULL with `b_ready_i` high in the same cycle.
  - On acceptance: `cnt_dec_o = 1`, which frees the counter entry.
  - On acceptance, load the register with `{b_i.id, resp_m, b_i.user}` → FULL.
- **Merged resp** `resp_m`:
  - = `b_i.resp` if `b_i.resp[1]`;
  - else = 2'b10 (SLVERR) if `cnt_err_i`;
  - else = `b_i.resp` (OKAY/EXOKAY passthrough).
- **Drain:** FULL with `b_ready_i` high and no last-beat load → EMPTY.
- `cnt_dec_o` and `cnt_set_err_o` are asserted only on a handshake (`b_valid_i & b_ready_o & cnt_gnt_i`).
- No grant → `b_ready_o = 0`, no counter side effects.

## Timing
- **Reset** (synchronous `rst_i` = 1 at a clock edge):
  - state EMPTY, `b_valid_o = 0`, `b_o = 0`.
  - Any beat in flight in the register is discarded.
  - Combinational outputs follow their equations; `b_ready_o` may be 1 during reset.
- **Latency:** last beat accepted in cycle N → `b_valid_o` high in cycle N+1.
- **Throughput:** one merged response per cycle under continuous `b_ready_i`. Refill while draining in the same cycle is mandatory; this creates a `b_ready_i` → `b_ready_o` combinational path.
- **Stability:** `b_o` is stable while `b_valid_o & !b_ready_i`, per the AXI valid/ready rules.
- **Simultaneous events**
  - Non-last absorb while FULL and stalled: allowed, register untouched.
  - Last beat while FULL and stalled: `b_ready_o = 0`, no `cnt_dec_o`.
- **Single-beat burst** (`cnt_len_i == 0` on the first beat): forwarded with resp rules unchanged.

## Structure
- Shared package `axi_burst_splitter_pkg`:
  - `b_chan_t` packed typedef;
  - resp constants `RESP_OKAY=2'b00`, `RESP_EXOKAY=2'b01`, `RESP_SLVERR=2'b10`, `RESP_DECERR=2'b11`.
- Sub-module `axi_burst_splitter_b_obuf`: one-entry output register with load/drain handshake, exposing `full_o` and `ready_for_load_o`.
- The top level holds the classification logic and the counter-port drive.

## Test plan
- **Single-beat burst:** ID 3, `cnt_len_i=0`, resp OKAY → `b_o = {3, OKAY}` next cycle, one `cnt_dec_o` pulse.
- **Error merge:** 4-beat burst ID 1 (len 3,2,1,0), beat 2 SLVERR, others OKAY →
  - `cnt_set_err_o` on beat 2;
  - exactly one upstream B: `{1, SLVERR}`;
  - 4 `cnt_dec_o` pulses.
- **Worst error wins:** last beat DECERR while `cnt_err_i=1` → upstream resp DECERR.
- **Back-pressure:** `b_ready_i=0` for 5 cycles with FULL →
  - interleaved non-last beats of ID 2 still accepted;
  - last beat of ID 2 stalls, no `cnt_dec_o`;
  - `b_o` held stable;
  - on release, drain and refill occur in the same cycle.
- **Back-to-back:** four single-beat bursts, IDs 0..3, `b_ready_i=1` → four upstream B on consecutive cycles, in order.
- **Reset mid-operation:** assert `rst_i` while FULL → `b_valid_o = 0` the next cycle, and the next merged response is correct.
